id_ex_stage: RTL and testbench

Decode/issue stage for the 64-bit pipelined core. It sits directly in front of the register file's read ports and behind the IF/ID register. Each cycle it decodes the instruction held in IF/ID, drives the register-file read addresses, and bypasses a same-cycle writeback. It detects load-use hazards and captures operands, immediate and control fields into the ID/EX pipeline register under a valid/ready handshake with stall and flush.

---
 rtl/id_ex_stage.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/issue stage for the 64-bit pipelined core.
// Decodes the IF/ID instruction, drives register-file read addresses,
// bypasses a same-cycle writeback, detects load-use hazards and loads the
// ID/EX pipeline register under a valid/ready handshake with stall and flush.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [31:0]      id_instr,
  output logic [4:0]       rf_rs1_addr,
  input  logic [XLEN-1:0]  rf_rs1_data,
  output logic [4:0]       rf_rs2_addr,
  input  logic [XLEN-1:0]  rf_rs2_data,
  input  logic             wb_wr_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_val,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [6:0]       ex_opcode,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic             ex_is_load,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0]      opcode;
  logic            rs1_used;
  logic            rs2_used;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            advance;
  logic            hazard;

  assign opcode = id_instr[6:0];

  // Source-use and immediate decode by opcode; unknown opcodes give a zero immediate
  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    imm      = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        rs1_used = 1'b0;
        imm      = {{(XLEN-32){id_instr[31]}}, id_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        rs1_used = 1'b0;
        imm      = {{(XLEN-21){id_instr[31]}}, id_instr[31], id_instr[19:12],
                    id_instr[20], id_instr[30:21], 1'b0};
      end
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: begin
        imm = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
      end
      OP_STORE: begin
        rs2_used = 1'b1;
        imm      = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      end
      OP_BRANCH: begin
        rs2_used = 1'b1;
        imm      = {{(XLEN-13){id_instr[31]}}, id_instr[31], id_instr[7],
                    id_instr[30:25], id_instr[11:8], 1'b0};
      end
      OP_OP, OP_OP32: begin
        rs2_used = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Unused sources collapse to x0 so they can never match a hazard or bypass
  assign rf_rs1_addr = rs1_used ? id_instr[19:15] : 5'd0;
  assign rf_rs2_addr = rs2_used ? id_instr[24:20] : 5'd0;

  // Operand select: x0 is hardwired zero, a same-cycle writeback beats the regfile
  always_comb begin
    rs1_val = rf_rs1_data;
    rs2_val = rf_rs2_data;
    if (rf_rs1_addr == 5'd0) begin
      rs1_val = '0;
    end else if (wb_wr_en && (wb_rd == rf_rs1_addr)) begin
      rs1_val = wb_data;
    end
    if (rf_rs2_addr == 5'd0) begin
      rs2_val = '0;
    end else if (wb_wr_en && (wb_rd == rf_rs2_addr)) begin
      rs2_val = wb_data;
    end
  end

  assign advance = !ex_valid || ex_ready;

  assign hazard = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                  ((ex_rd == rf_rs1_addr) || (ex_rd == rf_rs2_addr));

  assign id_ready = rst_n && (flush || (advance && !hazard));

  // ID/EX register: flush, hold (with writeback snoop), bubble, or capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_val  <= '0;
      ex_rs2_val  <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_is_load  <= 1'b0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (!advance) begin
      if (wb_wr_en && (wb_rd != 5'd0) && (wb_rd == ex_rs1)) begin
        ex_rs1_val <= wb_data;
      end
      if (wb_wr_en && (wb_rd != 5'd0) && (wb_rd == ex_rs2)) begin
        ex_rs2_val <= wb_data;
      end
    end else if (hazard) begin
      ex_valid <= 1'b0;
      if (bubble_cnt != {CNT_W{1'b1}}) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else if (id_valid) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rs1_val  <= rs1_val;
      ex_rs2_val  <= rs2_val;
      ex_imm      <= imm;
      ex_rs1      <= rf_rs1_addr;
      ex_rs2      <= rf_rs2_addr;
      ex_rd       <= id_instr[11:7];
      ex_opcode   <= opcode;
      ex_funct3   <= id_instr[14:12];
      ex_funct7b5 <= id_instr[30];
      ex_is_load  <= (opcode == OP_LOAD);
    end else begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector scoreboard bench for id_ex_stage.
// The driver pushes the hand-computed ID/EX contents of every instruction it
// issues; the monitor pops and compares whenever EX consumes a live slot.
module tb_id_ex_stage;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] rs1Val;
    logic [63:0] rs2Val;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        isLoad;
  } expT;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic [4:0]  rf_rs1_addr;
  logic [63:0] rf_rs1_data;
  logic [4:0]  rf_rs2_addr;
  logic [63:0] rf_rs2_data;
  logic        wb_wr_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic [63:0] ex_rs1_val;
  logic [63:0] ex_rs2_val;
  logic [63:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_is_load;
  logic [31:0] bubble_cnt;

  expT expQ[$];
  expT monE;
  int  compareCount = 0;
  int  mismatchCount = 0;

  id_ex_stage #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs1_data(rf_rs1_data),
    .rf_rs2_addr(rf_rs2_addr), .rf_rs2_data(rf_rs2_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_is_load(ex_is_load), .bubble_cnt(bubble_cnt)
  );

  // Register file stand-in: xN reads 0xA000+N, except x3 which reads 0
  assign rf_rs1_data = (rf_rs1_addr == 5'd3) ? 64'd0 : 64'hA000 + {59'd0, rf_rs1_addr};
  assign rf_rs2_data = (rf_rs2_addr == 5'd3) ? 64'd0 : 64'hA000 + {59'd0, rf_rs2_addr};

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something upstream never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic expT mkExp(input logic [63:0] pc, input logic [63:0] rs1Val,
                                input logic [63:0] rs2Val, input logic [63:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [6:0] opcode,
                                input logic [2:0] funct3, input logic funct7b5,
                                input logic isLoad);
    expT e;
    e.pc = pc; e.rs1Val = rs1Val; e.rs2Val = rs2Val; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.opcode = opcode;
    e.funct3 = funct3; e.funct7b5 = funct7b5; e.isLoad = isLoad;
    return e;
  endfunction

  // Present one instruction until accepted; counts cycles with id_ready low
  task automatic applyStimulus(input logic [63:0] pc, input logic [31:0] instr,
                               input expT e, input int expStalls);
    int lowCycles;
    bit accepted;
    lowCycles = 0;
    accepted  = 1'b0;
    id_pc    = pc;
    id_instr = instr;
    id_valid = 1'b1;
    expQ.push_back(e);
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      if (id_ready) accepted = 1'b1;
      else lowCycles++;
    end
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    checkOutput("accepted", {63'd0, accepted}, 64'd1);
    checkOutput("id_ready low cycles", 64'(lowCycles), 64'(expStalls));
  endtask

  // Scoreboard monitor: compare every slot EX consumes against the queue head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        compareCount++;
        mismatchCount++;
        $display("[TB] FAIL unexpected issue: got pc %h expected none", ex_pc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("ex_pc", ex_pc, monE.pc);
        checkOutput("ex_rs1_val", ex_rs1_val, monE.rs1Val);
        checkOutput("ex_rs2_val", ex_rs2_val, monE.rs2Val);
        checkOutput("ex_imm", ex_imm, monE.imm);
        checkOutput("ex_rs1", 64'(ex_rs1), 64'(monE.rs1));
        checkOutput("ex_rs2", 64'(ex_rs2), 64'(monE.rs2));
        checkOutput("ex_rd", 64'(ex_rd), 64'(monE.rd));
        checkOutput("ex_opcode", 64'(ex_opcode), 64'(monE.opcode));
        checkOutput("ex_funct3", 64'(ex_funct3), 64'(monE.funct3));
        checkOutput("ex_funct7b5", 64'(ex_funct7b5), 64'(monE.funct7b5));
        checkOutput("ex_is_load", 64'(ex_is_load), 64'(monE.isLoad));
      end
    end
  end

  // Directed sequence
  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    id_valid = 1'b1;
    id_pc    = 64'h100;
    id_instr = 32'hFFB00093;
    wb_wr_en = 1'b0;
    wb_rd    = 5'd0;
    wb_data  = 64'd0;
    ex_ready = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset ex_valid", {63'd0, ex_valid}, 64'd0);
    checkOutput("reset bubble_cnt", {32'd0, bubble_cnt}, 64'd0);
    checkOutput("reset id_ready", {63'd0, id_ready}, 64'd0);
    checkOutput("reset ex_pc", ex_pc, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADDI x1,x0,-5
    applyStimulus(64'h100, 32'hFFB00093,
      mkExp(64'h100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 5'd0, 5'd0, 5'd1,
            7'h13, 3'd0, 1'b1, 1'b0), 0);

    // ADD x4,x3,x3 with a same-cycle writeback of x3
    wb_wr_en = 1'b1; wb_rd = 5'd3; wb_data = 64'hDEAD;
    applyStimulus(64'h104, {7'b0, 5'd3, 5'd3, 3'b000, 5'd4, 7'h33},
      mkExp(64'h104, 64'hDEAD, 64'hDEAD, 64'd0, 5'd3, 5'd3, 5'd4,
            7'h33, 3'd0, 1'b0, 1'b0), 0);
    wb_wr_en = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;

    // LD x5,0(x2) then ADD x6,x5,x1: exactly one bubble
    applyStimulus(64'h108, {12'd0, 5'd2, 3'b011, 5'd5, 7'h03},
      mkExp(64'h108, 64'hA002, 64'd0, 64'd0, 5'd2, 5'd0, 5'd5,
            7'h03, 3'd3, 1'b0, 1'b1), 0);
    applyStimulus(64'h10C, {7'b0, 5'd1, 5'd5, 3'b000, 5'd6, 7'h33},
      mkExp(64'h10C, 64'hA005, 64'hA001, 64'd0, 5'd5, 5'd1, 5'd6,
            7'h33, 3'd0, 1'b0, 1'b0), 1);
    checkOutput("bubble_cnt after load-use", {32'd0, bubble_cnt}, 64'd1);

    // LD x8 then LUI x9 whose rs1 field is 8 but unused: no bubble
    applyStimulus(64'h110, {12'd8, 5'd2, 3'b011, 5'd8, 7'h03},
      mkExp(64'h110, 64'hA002, 64'd0, 64'd8, 5'd2, 5'd0, 5'd8,
            7'h03, 3'd3, 1'b0, 1'b1), 0);
    applyStimulus(64'h114, {20'h12345, 5'd9, 7'h37},
      mkExp(64'h114, 64'd0, 64'd0, 64'h1234_5000, 5'd0, 5'd0, 5'd9,
            7'h37, 3'd5, 1'b0, 1'b0), 0);
    checkOutput("bubble_cnt after LUI", {32'd0, bubble_cnt}, 64'd1);

    // ADD x10,x1,x2 then three cycles of back-pressure with a WB to x1
    applyStimulus(64'h118, {7'b0, 5'd2, 5'd1, 3'b000, 5'd10, 7'h33},
      mkExp(64'h118, 64'hBEEF, 64'hA002, 64'd0, 5'd1, 5'd2, 5'd10,
            7'h33, 3'd0, 1'b0, 1'b0), 0);
    ex_ready = 1'b0;
    id_valid = 1'b1;
    id_pc    = 64'h11C;
    id_instr = {12'd1, 5'd10, 3'b000, 5'd11, 7'h13};
    for (int h = 0; h < 3; h++) begin
      if (h == 1) begin
        wb_wr_en = 1'b1; wb_rd = 5'd1; wb_data = 64'hBEEF;
      end
      @(negedge clk);
      checkOutput("hold id_ready", {63'd0, id_ready}, 64'd0);
      checkOutput("hold ex_pc", ex_pc, 64'h118);
      checkOutput("hold ex_rs2_val", ex_rs2_val, 64'hA002);
      @(posedge clk);
      #1;
      wb_wr_en = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
    end
    checkOutput("snooped ex_rs1_val", ex_rs1_val, 64'hBEEF);
    ex_ready = 1'b1;

    // ADDI x11,x10,1 / SD x2,-8(x1) / BEQ x1,x2,+16 / JAL x1,-4
    applyStimulus(64'h11C, {12'd1, 5'd10, 3'b000, 5'd11, 7'h13},
      mkExp(64'h11C, 64'hA00A, 64'd0, 64'd1, 5'd10, 5'd0, 5'd11,
            7'h13, 3'd0, 1'b0, 1'b0), 0);
    applyStimulus(64'h120, {7'h7F, 5'd2, 5'd1, 3'b011, 5'b11000, 7'h23},
      mkExp(64'h120, 64'hA001, 64'hA002, 64'hFFFF_FFFF_FFFF_FFF8, 5'd1, 5'd2, 5'd24,
            7'h23, 3'd3, 1'b1, 1'b0), 0);
    applyStimulus(64'h124, {1'b0, 6'b0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0, 7'h63},
      mkExp(64'h124, 64'hA001, 64'hA002, 64'd16, 5'd1, 5'd2, 5'd16,
            7'h63, 3'd0, 1'b0, 1'b0), 0);
    applyStimulus(64'h128, 32'hFFDFF0EF,
      mkExp(64'h128, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0, 5'd1,
            7'h6F, 3'd7, 1'b1, 1'b0), 0);

    // LD x12, then a stalled hazard (no count), then flush during the hazard
    applyStimulus(64'h12C, {12'd0, 5'd2, 3'b011, 5'd12, 7'h03},
      mkExp(64'h12C, 64'hA002, 64'd0, 64'd0, 5'd2, 5'd0, 5'd12,
            7'h03, 3'd3, 1'b0, 1'b1), 0);
    ex_ready = 1'b0;
    id_valid = 1'b1;
    id_pc    = 64'h130;
    id_instr = {7'b0, 5'd0, 5'd12, 3'b000, 5'd13, 7'h33};
    @(negedge clk);
    checkOutput("stalled hazard id_ready", {63'd0, id_ready}, 64'd0);
    @(posedge clk);
    #1;
    ex_ready = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    checkOutput("stalled hazard bubble_cnt", {32'd0, bubble_cnt}, 64'd1);
    checkOutput("flush id_ready", {63'd0, id_ready}, 64'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    id_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush ex_valid", {63'd0, ex_valid}, 64'd0);
    checkOutput("flush bubble_cnt", {32'd0, bubble_cnt}, 64'd1);
    @(posedge clk);
    #1;

    // Redirected fetch re-presents ADD x13,x12,x0 into an empty EX
    applyStimulus(64'h130, {7'b0, 5'd0, 5'd12, 3'b000, 5'd13, 7'h33},
      mkExp(64'h130, 64'hA00C, 64'd0, 64'd0, 5'd12, 5'd0, 5'd13,
            7'h33, 3'd0, 1'b0, 1'b0), 0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    checkOutput("final bubble_cnt", {32'd0, bubble_cnt}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
